// File: rtl/pipe_hazard_ctrl.sv
// Y86 pipeline hazard/exception controller with memory wait-states and watchdog.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int DMEM_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic [2:0]       m_stat_i,
  input  logic [2:0]       W_stat_i,
  input  logic             imem_ready_i,
  input  logic             M_mem_req_i,
  input  logic             dmem_ready_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             E_stall_o,
  output logic             M_stall_o,
  output logic             W_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_bubble_o,
  output logic [1:0]       state_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;

  localparam int WC_RAW = $clog2(DMEM_TIMEOUT + 1);
  localparam int WC_W   = (WC_RAW < 1) ? 1 : WC_RAW;
  localparam bit WD_EN  = (DMEM_TIMEOUT > 0);
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'(WD_EN ? DMEM_TIMEOUT - 1 : 0);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(DMEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_DRAIN = 2'b01,
    S_HALT  = 2'b10,
    S_BAD   = 2'b11
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_halted;
  logic            r_fault;
  logic [WC_W-1:0] r_wait_cnt;

  logic w_exc_m;
  logic w_exc_w;
  logic w_load_use;
  logic w_ret;
  logic w_mispred;
  logic w_dwait;
  logic w_iwait;
  logic w_halt;
  logic w_run_dwait;
  logic w_wd_exp;

  assign w_exc_m = (m_stat_i == SHLT) | (m_stat_i == SADR) |
                   (m_stat_i == SINS);
  assign w_exc_w = (W_stat_i == SHLT) | (W_stat_i == SADR) |
                   (W_stat_i == SINS);

  assign w_load_use = ((E_icode_i == IMRMOVQ) | (E_icode_i == IPOPQ)) &
                      (E_dstM_i != RNONE) &
                      ((E_dstM_i == d_srcA_i) | (E_dstM_i == d_srcB_i));
  assign w_ret      = (D_icode_i == IRET) | (E_icode_i == IRET) |
                      (M_icode_i == IRET);
  assign w_mispred  = (E_icode_i == IJXX) & ~e_Cnd_i;
  assign w_dwait    = M_mem_req_i & ~dmem_ready_i;
  assign w_iwait    = ~imem_ready_i;

  assign w_halt      = (r_state == S_HALT);
  assign w_run_dwait = w_dwait & ~w_halt;
  assign w_wd_exp    = WD_EN & w_dwait & (r_wait_cnt == WC_LAST);

  always_comb begin
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    E_stall_o  = 1'b0;
    M_stall_o  = 1'b0;
    W_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    W_bubble_o = 1'b0;
    unique case (1'b1)
      w_halt: begin
        F_stall_o = 1'b1;
        D_stall_o = 1'b1;
        E_stall_o = 1'b1;
        M_stall_o = 1'b1;
        W_stall_o = 1'b1;
      end
      w_run_dwait: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_stall_o  = 1'b1;
        M_stall_o  = 1'b1;
        W_stall_o  = w_exc_w;
        W_bubble_o = ~w_exc_w;
      end
      default: begin
        F_stall_o  = w_load_use | w_ret | w_iwait;
        D_stall_o  = w_load_use;
        D_bubble_o = w_mispred | (~w_load_use & (w_ret | w_iwait));
        E_bubble_o = w_load_use | w_mispred;
        M_bubble_o = w_exc_m | w_exc_w;
        W_stall_o  = w_exc_w;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_exc_w | w_wd_exp)
          w_state_nxt = S_HALT;
        else if (w_exc_m)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_exc_w | w_wd_exp)
          w_state_nxt = S_HALT;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_RUN;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == S_HALT);
      if (w_wd_exp)
        r_fault <= 1'b1;
      if (!w_dwait)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != WC_MAX)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign state_o  = r_state;
  assign halted_o = r_halted;
  assign fault_o  = r_fault;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // flushes are only counted when the bubble actually lands (not held by dwait)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (F_stall_o && !w_halt && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_mispred && !w_halt && !w_dwait && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DMEM_TIMEOUT=4, CNT_W=4).
// Counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] D_icode, E_icode, M_icode;
  logic [3:0] d_srcA, d_srcB, E_dstM;
  logic       e_Cnd;
  logic [2:0] m_stat, W_stat;
  logic       imem_ready, M_mem_req, dmem_ready;
  logic       F_stall, D_stall, E_stall, M_stall, W_stall;
  logic       D_bubble, E_bubble, M_bubble, W_bubble;
  logic [1:0] state;
  logic       halted, fault;
  logic [3:0] stall_cnt, flush_cnt;
  logic [8:0] ctl;

  int n_chk;
  int n_fail;

  pipe_hazard_ctrl #(
    .DMEM_TIMEOUT(4),
    .CNT_W(4)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .D_icode_i(D_icode),
    .E_icode_i(E_icode),
    .M_icode_i(M_icode),
    .d_srcA_i(d_srcA),
    .d_srcB_i(d_srcB),
    .E_dstM_i(E_dstM),
    .e_Cnd_i(e_Cnd),
    .m_stat_i(m_stat),
    .W_stat_i(W_stat),
    .imem_ready_i(imem_ready),
    .M_mem_req_i(M_mem_req),
    .dmem_ready_i(dmem_ready),
    .F_stall_o(F_stall),
    .D_stall_o(D_stall),
    .E_stall_o(E_stall),
    .M_stall_o(M_stall),
    .W_stall_o(W_stall),
    .D_bubble_o(D_bubble),
    .E_bubble_o(E_bubble),
    .M_bubble_o(M_bubble),
    .W_bubble_o(W_bubble),
    .state_o(state),
    .halted_o(halted),
    .fault_o(fault),
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
  );

  // {F,D,E,M,W stall, D,E,M,W bubble}
  assign ctl = {F_stall, D_stall, E_stall, M_stall, W_stall,
                D_bubble, E_bubble, M_bubble, W_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    D_icode    = 4'h1;
    E_icode    = 4'h1;
    M_icode    = 4'h1;
    d_srcA     = 4'hF;
    d_srcB     = 4'hF;
    E_dstM     = 4'hF;
    e_Cnd      = 1'b1;
    m_stat     = 3'd1;
    W_stat     = 3'd1;
    imem_ready = 1'b1;
    M_mem_req  = 1'b0;
    dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_ctl", 32'(ctl), 32'h000);
    check("rst_scnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // load-use, then RNONE destination
    @(negedge clk);
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1 check("lu_ctl", 32'(ctl), 32'b110000100);
    E_dstM = 4'hF; d_srcA = 4'hF;
    #1 check("lu_rnone", 32'(ctl), 32'b000000000);
    E_icode = 4'hB; E_dstM = 4'h6; d_srcB = 4'h6;
    #1 check("lu_popq_srcB", 32'(ctl), 32'b110000100);
    idle();

    // ret with imem not ready
    D_icode = 4'h9; imem_ready = 1'b0;
    #1 check("ret_iwait", 32'(ctl), 32'b100001000);
    idle();
    M_icode = 4'h9;
    #1 check("ret_in_M", 32'(ctl), 32'b100001000);

    // mispredict during data wait
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      E_icode = 4'h7; e_Cnd = 1'b0;
      M_mem_req = 1'b1; dmem_ready = 1'b0;
      #1 check($sformatf("mp_dwait%0d", i), 32'(ctl), 32'b111100001);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1 check("mp_after", 32'(ctl), 32'b000001100);
    @(posedge clk);
    #1;
    check("mp_flush", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
    check("mp_scnt", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);
    check("mp_nofault", 32'(fault), 32'd0);

    // dwait with W exception holds W instead of bubbling
    @(negedge clk);
    idle();
    M_mem_req = 1'b1; dmem_ready = 1'b0; W_stat = 3'd4;
    #1 check("dwait_excW", 32'(ctl), 32'b111110000);

    // exception drain then halt
    do_reset();
    @(negedge clk);
    m_stat = 3'd3;
    #1 check("exc_mbub", 32'(ctl), 32'b000000010);
    check("exc_run", 32'(state), 32'd0);
    @(negedge clk);
    check("exc_drain", 32'(state), 32'd1);
    check("exc_drain_h", 32'(halted), 32'd0);
    m_stat = 3'd1; W_stat = 3'd3;
    #1 check("exc_wstall", 32'(ctl), 32'b000010010);
    @(negedge clk);
    check("exc_halt", 32'(state), 32'd2);
    check("exc_halted", 32'(halted), 32'd1);
    idle();
    #1 check("halt_ctl", 32'(ctl), 32'b111110000);
    M_mem_req = 1'b1; dmem_ready = 1'b0;
    #1 check("halt_dwait", 32'(ctl), 32'b111110000);
    @(negedge clk);
    idle();
    check("halt_absorb", 32'(state), 32'd2);

    // watchdog expiry after 4 wait cycles
    do_reset();
    @(negedge clk);
    M_mem_req = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wd_edge3_f", 32'(fault), 32'd0);
    check("wd_edge3_s", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    check("wd_fault", 32'(fault), 32'd1);
    check("wd_halt", 32'(state), 32'd2);
    check("wd_halted", 32'(halted), 32'd1);

    // async reset while halted
    #2 rst_n = 1'b0;
    #1;
    check("ar_state", 32'(state), 32'd0);
    check("ar_fault", 32'(fault), 32'd0);
    check("ar_halted", 32'(halted), 32'd0);
    check("ar_scnt", 32'(stall_cnt), 32'd0);
    check("ar_fcnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // dmem_ready arrives on the would-be expiry cycle
    do_reset();
    @(negedge clk);
    M_mem_req = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dmem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("wd_ok_fault", 32'(fault), 32'd0);
    check("wd_ok_state", 32'(state), 32'd0);
    @(negedge clk);
    dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("wd_cnt_clr", 32'(fault), 32'd0);

    // stall counter saturation
    do_reset();
    @(negedge clk);
    imem_ready = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    check("sat_scnt", 32'(stall_cnt), PERF ? 32'd15 : 32'd0);
    check("sat_state", 32'(state), 32'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised Y86 pipeline hazard and exception controller, sitting beside the five-stage datapath and driving the stall/bubble inputs of the F, D, E, M and W pipeline registers. It covers load-use, `ret` and mispredicted-branch hazards, and adds two things to them: wait-state handling for instruction and data memories with ready handshakes, and a registered exception/halt state machine. It also has a data-memory timeout watchdog and optional performance counters.

## Interface
Parameters:
- `DMEM_TIMEOUT`, default 16: maximum consecutive data-memory wait cycles before a fault; 0 disables the watchdog.
- `CNT_W`, default 32: performance counter width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `D_icode_i`, `E_icode_i`, `M_icode_i`  in  4  stage icodes.
- `d_srcA_i`, `d_srcB_i`, `E_dstM_i`  in  4  register IDs; `RNONE`=4'hF.
- `e_Cnd_i`  in  1  branch condition from E.
- `m_stat_i`, `W_stat_i`  in  3  status codes: `SAOK`=1, `SHLT`=2, `SADR`=3, `SINS`=4.
- `imem_ready_i`  in  1  fetch data valid this cycle.
- `M_mem_req_i`  in  1  M stage accesses data memory this cycle.
- `dmem_ready_i`  in  1  data memory completes the access this cycle.
- `F_stall_o`, `D_stall_o`, `E_stall_o`, `M_stall_o`, `W_stall_o`  out  1  stage stalls.
- `D_bubble_o`, `E_bubble_o`, `M_bubble_o`, `W_bubble_o`  out  1  stage bubbles.
- `state_o`  out  2  FSM state.
- `halted_o`  out  1  FSM in HALT.
- `fault_o`  out  1  sticky; set on watchdog timeout.
- `stall_cnt_o`, `flush_cnt_o`  out  `CNT_W`  performance counters.

## Operation
Hazard terms, all combinational:
- exc(s) = s ∈ {SHLT, SADR, SINS}.
- load_use = E_icode ∈ {IMRMOVQ=5, IPOPQ=B}, and E_dstM ≠ RNONE, and E_dstM equals d_srcA or d_srcB.
- ret = IRET(9) present in D, E or M.
- mispredict = E_icode = IJXX(7) and ~e_Cnd.
- dwait = M_mem_req & ~dmem_ready.
- iwait = ~imem_ready.

Output priority, highest first:
1. HALT state:
   - F/D/E/M/W stall = 1.
   - All bubbles = 0.
2. dwait (outside HALT):
   - F/D/E/M stall = 1.
   - If exc(W_stat): W_stall = 1; otherwise W_bubble = 1.
   - All other outputs = 0.
3. Normal operation:
   - F_stall = load_use | ret | iwait.
   - D_stall = load_use.
   - D_bubble = mispredict | (~load_use & (ret | iwait)).
   - E_bubble = load_use | mispredict.
   - M_bubble = exc(m_stat) | exc(W_stat).
   - W_stall = exc(W_stat).
   - E_stall, M_stall, W_bubble = 0.

FSM, state_o encodings:
- RUN (00):
  - Go to DRAIN if exc(m_stat) and not exc(W_stat).
  - Go to HALT if exc(W_stat).
- DRAIN (01): go to HALT when exc(W_stat).
- HALT (10): absorbing; only reset leaves it. halted_o = 1.
- 11 is unreachable. If it is ever decoded, go to HALT.

Watchdog:
- wait_cnt counts consecutive dwait cycles and clears on any non-dwait cycle.
- When DMEM_TIMEOUT > 0 and wait_cnt reaches DMEM_TIMEOUT−1 with dwait still high, the next edge sets fault_o and moves the FSM to HALT.
- wait_cnt is sized $clog2(DMEM_TIMEOUT+1) bits, minimum 1.

## Timing
- All stall/bubble outputs are combinational, same cycle as the inputs, with no latency.
- state_o, halted_o and fault_o are registered and change on the edge after the triggering condition.
- A HALT entered from exc(W_stat) takes effect the cycle after W_stat shows the exception. During that triggering cycle the outputs follow rule 3 (or rule 2 if dwait).
- Reset values:
  - state_o = RUN; halted_o = 0; fault_o = 0; wait_cnt = 0; counters = 0.
  - Stall/bubble outputs reflect the inputs with state = RUN.
- Asserting reset mid-operation, including in HALT or during dwait, clears all state immediately and asynchronously.
- When dwait and mispredict occur together, dwait wins. The mispredict bubble is applied in the first cycle after dmem_ready, because E is held.
- If dmem_ready is high in the same cycle the watchdog would expire, there is no fault.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - stall_cnt_o increments each cycle F_stall_o = 1 while state ≠ HALT.
  - flush_cnt_o increments each cycle mispredict = 1 outside HALT and dwait.
  - Both saturate at all-ones.
- `PIPE_PERF_CNT_EN` undefined: counter registers are absent and both outputs are tied to 0.

## Test plan
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. Repeat with E_dstM=F, d_srcA=F -> all 0.
- Mispredict during data wait: E_icode=7, e_Cnd=0, M_mem_req=1, dmem_ready=0 for 3 cycles -> F/D/E/M stall=1 and W_bubble=1 for 3 cycles. Next cycle: D_bubble=1, E_bubble=1. flush_cnt_o=1.
- Ret with imem not ready: D_icode=9, imem_ready=0 -> F_stall=1, D_bubble=1, D_stall=0.
- Exception: m_stat=3 at cycle N -> M_bubble=1 and state=DRAIN at N+1. W_stat=3 at N+1 -> W_stall=1 and state=HALT, halted_o=1 at N+2, all stalls=1 thereafter.
- Watchdog: DMEM_TIMEOUT=4, dwait held 4 cycles -> fault_o=1 and state=HALT after the 4th edge. A second run with dmem_ready=1 on the 4th cycle -> no fault.
- Reset in HALT: assert rst_n_i=0 asynchronously mid-cycle -> state_o=00, fault_o=0, counters=0 immediately. With the macro on and F_stall held for 2^CNT_W+5 cycles (CNT_W=4), stall_cnt_o saturates at 15.
